// File: rtl/pkt_arb2.sv
// Two-source packet arbiter: per-source FIFOs, round-robin grant, registered merged output.
// Optional grant statistics are enabled by defining PKT_ARB2_STATS_EN.
module pkt_arb2 #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [3:0]  s0_id,
    input  logic [3:0]  s0_opcode,
    input  logic [15:0] s0_payload,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [3:0]  s1_id,
    input  logic [3:0]  s1_opcode,
    input  logic [15:0] s1_payload,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_id,
    output logic [3:0]  m_opcode,
    output logic [15:0] m_payload,
    output logic        m_src,
    input  logic        stats_clr,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PKT_W = 24;

    logic [PKT_W-1:0] in_pkt [2];
    logic [1:0]       in_valid;
    logic [PKT_W-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] cnt    [2];
    logic [1:0]       full;
    logic [1:0]       nonempty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             prio;
    logic             grant;
    logic             load;
    logic [PKT_W-1:0] head;

    assign in_pkt[0] = {s0_id, s0_opcode, s0_payload};
    assign in_pkt[1] = {s1_id, s1_opcode, s1_payload};
    assign in_valid  = {s1_valid, s0_valid};

    // Ready depends only on registered occupancy, never on m_ready.
    assign s0_ready = !full[0];
    assign s1_ready = !full[1];

    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            full[k]     = (cnt[k] == CNT_W'(DEPTH));
            nonempty[k] = (cnt[k] != '0);
        end
        push  = in_valid & ~full;
        load  = !m_valid || m_ready;
        // With a single non-empty FIFO that one wins; prio only breaks ties.
        grant = (nonempty == 2'b11) ? prio : nonempty[1];
        pop   = '0;
        if (load && (nonempty != '0)) begin
            pop[grant] = 1'b1;
        end
        head = mem[grant][rd_ptr[grant]];
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= in_pkt[k];
            end
        end
    end

    // DEPTH is a power of two, so pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                cnt[k] <= cnt[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_id      <= '0;
            m_opcode  <= '0;
            m_payload <= '0;
            m_src     <= 1'b0;
            prio      <= 1'b0;
        end else if (load) begin
            if (pop != '0) begin
                {m_id, m_opcode, m_payload} <= head;
                m_src   <= grant;
                m_valid <= 1'b1;
                prio    <= !grant;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef PKT_ARB2_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (m_valid && m_ready) begin
            if (m_src) begin
                grant_cnt1 <= grant_cnt1 + 32'd1;
            end else begin
                grant_cnt0 <= grant_cnt0 + 32'd1;
            end
        end
    end
`else
    logic stats_clr_unused;
    assign stats_clr_unused = stats_clr;
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
